// File: rtl/lag_measure_pkg.sv
// rtl/lag_measure_pkg.sv - shared widths, FSM states and helpers for the lag measurement block
package lag_measure_pkg;

  localparam int LAG_US_WIDTH = 17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEASURE   = 2'd1,
    WAIT_DARK = 2'd2
  } state_e;

  // A zero cycles-per-microsecond setting behaves as one cycle per microsecond.
  function automatic logic [7:0] eff_cpu(input logic [7:0] cpu);
    return (cpu == 8'd0) ? 8'd1 : cpu;
  endfunction

endpackage

// File: rtl/lag_measure_sync_debounce.sv
// rtl/lag_measure_sync_debounce.sv - photodiode synchronizer with level-stability counter
// stable_high/stable_low assert once the current level has held for DEBOUNCE_CYCLES cycles.
module lag_measure_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sensor,
  output logic sens_s,
  output logic rise,
  output logic stable_high,
  output logic stable_low
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] run_q, run_d;

  // run_d is the length of the current level run including this cycle; it saturates at CMAX.
  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    run_d   = run_q;
    if (sync2_q != prev_q) begin
      run_d = CW'(1);
    end else if (run_q < CMAX) begin
      run_d = run_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
    end
  end

  assign sens_s      = sync2_q;
  assign rise        = sync2_q & ~prev_q;
  assign stable_high = sync2_q & (run_d == CMAX);
  assign stable_low  = ~sync2_q & (run_d == CMAX);

endmodule

// File: rtl/lag_measure.sv
// rtl/lag_measure.sv - times trigger-to-flash lag in microseconds and averages accepted samples
// Holds the measurement FSM, the microsecond prescaler and the running averager.
module lag_measure
  import lag_measure_pkg::*;
#(
  parameter int TIMEOUT_US       = 100000,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int AVG_SAMPLES_LOG2 = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [7:0]                  cycles_per_us,
  input  logic                        starttrigger,
  input  logic                        sensor,
  output logic [LAG_US_WIDTH-1:0]     lag_us,
  output logic                        lag_valid,
  output logic [LAG_US_WIDTH-1:0]     avg_us,
  output logic                        avg_valid,
  output logic                        timeout,
  output logic [AVG_SAMPLES_LOG2-1:0] sample_count,
  output logic                        busy
);

  localparam int ACC_W = LAG_US_WIDTH + AVG_SAMPLES_LOG2;
  localparam logic [LAG_US_WIDTH-1:0] TIMEOUT_V = LAG_US_WIDTH'(TIMEOUT_US);
  localparam logic [AVG_SAMPLES_LOG2-1:0] CNT_LAST = '1;

  logic sens_s, rise, stable_high, stable_low;

  lag_measure_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .sensor     (sensor),
    .sens_s     (sens_s),
    .rise       (rise),
    .stable_high(stable_high),
    .stable_low (stable_low)
  );

  state_e                      state_q, state_d;
  logic [7:0]                  presc_q, presc_d;
  logic [LAG_US_WIDTH-1:0]     us_q, us_d;
  logic [LAG_US_WIDTH-1:0]     cand_q, cand_d;
  logic [LAG_US_WIDTH-1:0]     lag_us_q, lag_us_d;
  logic                        lag_valid_q, lag_valid_d;
  logic [LAG_US_WIDTH-1:0]     avg_us_q, avg_us_d;
  logic                        avg_valid_q, avg_valid_d;
  logic                        timeout_q, timeout_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [AVG_SAMPLES_LOG2-1:0] cnt_q, cnt_d;
  logic                        avg_pend_q, avg_pend_d;
  logic                        busy_q, busy_d;

  logic [7:0]              presc_max;
  logic [LAG_US_WIDTH-1:0] accept_us;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    us_d        = us_q;
    cand_d      = cand_q;
    lag_us_d    = lag_us_q;
    lag_valid_d = 1'b0;
    avg_us_d    = avg_us_q;
    avg_valid_d = 1'b0;
    timeout_d   = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_pend_d  = avg_pend_q;
    presc_max   = eff_cpu(cycles_per_us) - 8'd1;
    // With a one-cycle debounce the candidate is accepted in its own rise cycle.
    accept_us   = rise ? us_q : cand_q;

    // >= lets a lowered cycles_per_us wrap immediately instead of running to 255.
    if (presc_q >= presc_max) begin
      presc_d = 8'd0;
      if (us_q != TIMEOUT_V) begin
        us_d = us_q + LAG_US_WIDTH'(1);
      end
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (avg_pend_q) begin
      avg_us_d    = acc_q[ACC_W-1:AVG_SAMPLES_LOG2];
      avg_valid_d = 1'b1;
      acc_d       = '0;
      avg_pend_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (starttrigger) begin
          if (sens_s) begin
            state_d = WAIT_DARK;
          end else begin
            state_d = MEASURE;
            presc_d = 8'd0;
            us_d    = '0;
          end
        end
      end
      MEASURE: begin
        if (rise) begin
          cand_d = us_q;
        end
        if (us_q == TIMEOUT_V) begin
          timeout_d = 1'b1;
          state_d   = WAIT_DARK;
        end else if (stable_high) begin
          lag_us_d    = accept_us;
          lag_valid_d = 1'b1;
          acc_d       = acc_q + {{AVG_SAMPLES_LOG2{1'b0}}, accept_us};
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            avg_pend_d = 1'b1;
          end
          state_d = WAIT_DARK;
        end
      end
      WAIT_DARK: begin
        if (stable_low) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      presc_q     <= 8'd0;
      us_q        <= '0;
      cand_q      <= '0;
      lag_us_q    <= '0;
      lag_valid_q <= 1'b0;
      avg_us_q    <= '0;
      avg_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      us_q        <= us_d;
      cand_q      <= cand_d;
      lag_us_q    <= lag_us_d;
      lag_valid_q <= lag_valid_d;
      avg_us_q    <= avg_us_d;
      avg_valid_q <= avg_valid_d;
      timeout_q   <= timeout_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_pend_q  <= avg_pend_d;
      busy_q      <= busy_d;
    end
  end

  assign lag_us       = lag_us_q;
  assign lag_valid    = lag_valid_q;
  assign avg_us       = avg_us_q;
  assign avg_valid    = avg_valid_q;
  assign timeout      = timeout_q;
  assign sample_count = cnt_q;
  assign busy         = busy_q;

endmodule
